// File: rtl/uart_top_loopback.sv
// ---------------------------------------------------------------------------
// uart_top_loopback
//   8N1 UART echo: every byte received correctly on rxd is retransmitted
//   unchanged on txd. Mid-bit sampling receiver (no oversampling), a byte
//   buffer, and a transmitter that all share one baud divisor.
//
// Parameters
//   CLK_FREQ  input clock frequency in Hz
//   BAUD      line rate in bit/s; DIV = CLK_FREQ / BAUD, HALF = DIV / 2
//
// Ports
//   clk    system clock, all logic on the rising edge
//   rst_n  reset, synchronous and ACTIVE-HIGH despite the name
//          (board-level pin name is kept for compatibility)
//   rxd    serial receive line, asynchronous, idle high
//   txd    serial transmit line, registered, idle high
//
// Configuration
//   UART_LOOPBACK_FIFO_EN  defined: 16-entry FIFO buffer
//                          undefined: single-byte holding register
// ---------------------------------------------------------------------------
module uart_top_loopback #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic txd
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 2;
  localparam int unsigned BIT_W = 3;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(7);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  // The reset pin is active-high; alias it so the logic reads naturally.
  logic rst;
  assign rst = rst_n;

  // -------------------------------------------------------------------------
  // Receiver
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t        rx_state;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
  logic [CNT_W-1:0] rx_cnt;
  logic [BIT_W-1:0] rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_done;

  // Two-flop synchronizer, edge detector and mid-bit sampling FSM.
  // rx_done pulses for one cycle after a stop bit is sampled high; rx_shift
  // holds the byte stable until the next start bit is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_done <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s2) begin
            rx_bit   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            // A line that is high again at mid start bit was a glitch.
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == BIT_LAST) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + BIT_ONE;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            // Low stop bit is a framing error: byte silently discarded.
            rx_done  <= rx_s2;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Byte buffer between receiver and transmitter
  // -------------------------------------------------------------------------
  logic       tx_pop_c;
  logic       buf_wr_c;
  logic       buf_empty_c;
  logic [7:0] buf_head_c;

`ifdef UART_LOOPBACK_FIFO_EN
  localparam int unsigned PTR_W = 4;
  localparam int unsigned DEPTH = 1 << PTR_W;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [7:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             fifo_full;
  logic             fifo_empty;

  // A full FIFO still accepts a write in the same cycle as a pop.
  assign buf_wr_c    = rx_done && (!fifo_full || tx_pop_c);
  assign buf_empty_c = fifo_empty;
  assign buf_head_c  = fifo_mem[rd_ptr];

  // Storage array, no reset needed: contents are qualified by the flags.
  always_ff @(posedge clk) begin
    if (buf_wr_c) begin
      fifo_mem[wr_ptr] <= rx_shift;
    end
  end

  // Wrapping pointers with explicit full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      if (buf_wr_c) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (tx_pop_c) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({buf_wr_c, tx_pop_c})
        2'b10: begin
          fifo_empty <= 1'b0;
          fifo_full  <= ((wr_ptr + PTR_ONE) == rd_ptr);
        end
        2'b01: begin
          fifo_full  <= 1'b0;
          fifo_empty <= ((rd_ptr + PTR_ONE) == wr_ptr);
        end
        default: begin
          fifo_full  <= fifo_full;
          fifo_empty <= fifo_empty;
        end
      endcase
    end
  end
`else
  logic [7:0] hold_data;
  logic       hold_valid;

  // A byte arriving while the register is still occupied is dropped,
  // unless the transmitter pops the old byte in that same cycle.
  assign buf_wr_c    = rx_done && (!hold_valid || tx_pop_c);
  assign buf_empty_c = !hold_valid;
  assign buf_head_c  = hold_data;

  // Single-byte holding register with valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (buf_wr_c) begin
        hold_data  <= rx_shift;
        hold_valid <= 1'b1;
      end else if (tx_pop_c) begin
        hold_valid <= 1'b0;
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Transmitter
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [BIT_W-1:0] tx_bit;
  logic [7:0]       tx_shift;

  // Pop when idle, or at the last cycle of a stop bit so that a queued byte
  // starts in the very next cycle with no idle gap.
  assign tx_pop_c = !buf_empty_c &&
                    ((tx_state == TX_IDLE) ||
                     ((tx_state == TX_STOP) && (tx_cnt == DIV_LAST)));

  // Frame generator; txd is driven straight from this register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          txd    <= 1'b1;
          if (tx_pop_c) begin
            tx_shift <= buf_head_c;
            txd      <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_DATA: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == BIT_LAST) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_shift <= {1'b0, tx_shift[7:1]};
              txd      <= tx_shift[1];
              tx_bit   <= tx_bit + BIT_ONE;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_STOP: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_pop_c) begin
              tx_shift <= buf_head_c;
              txd      <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_top_loopback.sv
// ---------------------------------------------------------------------------
// tb_uart_top_loopback
//   Directed bench for the UART loopback at default parameters (DIV = 434).
//   rxd is driven and txd sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_uart_top_loopback;

  localparam int DIV = 434;
  // Cycles from the rxd fall to the stop-bit sample: 3 + HALF + 9*DIV.
  localparam int STOP_SAMPLE = 3 + 217 + 9 * 434;

  logic clk = 1'b0;
  logic rst_n;
  logic rxd;
  logic txd;

  int unsigned cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_top_loopback dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .txd   (txd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

  // Start bit plus 8 data bits LSB first, optional stop bit, then idle high.
  task automatic send_bits(input logic [7:0] data, input logic stop_bit, input bit with_stop);
    rxd = 1'b0;
    repeat (DIV) step();
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (DIV) step();
    end
    if (with_stop) begin
      rxd = stop_bit;
      repeat (DIV) step();
    end
    rxd = 1'b1;
  endtask

  // Checks the current cycle first, then advances up to budget-1 cycles.
  task automatic wait_start(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (txd === 1'b0) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Called on the first cycle of a start bit; returns on the cycle after stop.
  task automatic capture(output logic [9:0] frame, output bit stable);
    stable = 1'b1;
    frame  = '0;
    for (int b = 0; b < 10; b++) begin
      frame[b] = txd;
      for (int c = 1; c < DIV; c++) begin
        step();
        if (txd !== frame[b]) stable = 1'b0;
      end
      step();
    end
  endtask

  task automatic count_low(input int cycles, output int lows);
    lows = 0;
    repeat (cycles) begin
      step();
      if (txd !== 1'b1) lows++;
    end
  endtask

  bit          found_a, found_b, stable_a, stable_b;
  logic [9:0]  frame_a, frame_b;
  int unsigned c0, t_a, t_end;
  int          lows, lat;
`ifdef UART_LOOPBACK_FIFO_EN
  bit          found_c, stable_c;
  logic [9:0]  frame_c;
`endif

  initial begin
    rxd   = 1'b1;
    rst_n = 1'b1;

    // Reset held for 5 cycles, then a long quiet window.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_txd", 32'(txd), 32'd1);
    end
    rst_n = 1'b0;
    count_low(20 * DIV, lows);
    chk("reset_quiet_lows", 32'(lows), 32'd0);

    // Single byte 0x55 echoed with exact bit widths.
    c0 = cyc;
    send_bits(8'h55, 1'b1, 1'b0);
    wait_start(2000, found_a);
    t_a = cyc;
    chk("single_found", 32'(found_a), 32'd1);
    lat = int'(t_a - c0) - STOP_SAMPLE;
    chk("single_latency_1to3", 32'(lat >= 1 && lat <= 3), 32'd1);
    capture(frame_a, stable_a);
    chk("single_frame", 32'(frame_a), 32'(frame_of(8'h55)));
    chk("single_widths", 32'(stable_a), 32'd1);

    // Framing error: 0xA3 with low stop bit is discarded.
    send_bits(8'hA3, 1'b0, 1'b1);
    count_low(20 * DIV, lows);
    chk("framing_quiet_lows", 32'(lows), 32'd0);

    // 50-cycle glitch is rejected at the mid start-bit sample.
    rxd = 1'b0;
    repeat (50) step();
    rxd = 1'b1;
    count_low(20 * DIV, lows);
    chk("glitch_quiet_lows", 32'(lows), 32'd0);

    // Back-to-back 0x00 then 0xFF with no idle gap on either side.
    fork
      begin
        send_bits(8'h00, 1'b1, 1'b1);
        send_bits(8'hFF, 1'b1, 1'b0);
      end
      begin
        wait_start(6000, found_a);
        t_a = cyc;
        capture(frame_a, stable_a);
        wait_start(1, found_b);
        capture(frame_b, stable_b);
        t_end = cyc;
      end
    join
    chk("b2b_found_0", 32'(found_a), 32'd1);
    chk("b2b_frame_0", 32'(frame_a), 32'(frame_of(8'h00)));
    chk("b2b_widths_0", 32'(stable_a), 32'd1);
    chk("b2b_found_1", 32'(found_b), 32'd1);
    chk("b2b_frame_1", 32'(frame_b), 32'(frame_of(8'hFF)));
    chk("b2b_widths_1", 32'(stable_b), 32'd1);
    chk("b2b_total_cycles", t_end - t_a, 32'(20 * DIV));

`ifdef UART_LOOPBACK_FIFO_EN
    // Three consecutive bytes echoed in order, contiguous.
    fork
      begin
        send_bits(8'h12, 1'b1, 1'b1);
        send_bits(8'h34, 1'b1, 1'b1);
        send_bits(8'h56, 1'b1, 1'b0);
      end
      begin
        wait_start(6000, found_a);
        capture(frame_a, stable_a);
        wait_start(1, found_b);
        capture(frame_b, stable_b);
        wait_start(1, found_c);
        capture(frame_c, stable_c);
      end
    join
    chk("fifo3_found", 32'({found_a, found_b, found_c}), 32'h7);
    chk("fifo3_frame_0", 32'(frame_a), 32'(frame_of(8'h12)));
    chk("fifo3_frame_1", 32'(frame_b), 32'(frame_of(8'h34)));
    chk("fifo3_frame_2", 32'(frame_c), 32'(frame_of(8'h56)));
    chk("fifo3_widths", 32'({stable_a, stable_b, stable_c}), 32'h7);
`endif

    // Reset in the middle of TX data bit 4 of 0x0F (a 0 bit).
    send_bits(8'h0F, 1'b1, 1'b0);
    wait_start(2000, found_a);
    chk("midtx_found", 32'(found_a), 32'd1);
    repeat (5 * DIV + 200) step();
    chk("midtx_bit4_level", 32'(txd), 32'd0);
    rst_n = 1'b1;
    step();
    chk("midtx_reset_txd", 32'(txd), 32'd1);
    rst_n = 1'b0;
    count_low(10 * DIV, lows);
    chk("midtx_after_quiet_lows", 32'(lows), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_top_loopback.md
# uart_top_loopback

8N1 UART loopback block: every byte correctly received on `rxd` is retransmitted unchanged on `txd`. Top level of the UART subsystem, driven directly by the 50 MHz board clock and the board serial pins. It contains an oversampling-free receiver (mid-bit sampling), a byte buffer, and a transmitter sharing one baud divisor.

## Interface
- `CLK_FREQ`, 50_000_000, input clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s; divisor `DIV = CLK_FREQ / BAUD` (integer truncation, 434 at defaults), half-bit `HALF = DIV / 2` (217)
- `clk`  input  1  system clock, all logic on rising edge
- `rst_n`  input  1  reset; one clock; reset is synchronous and active-high
- `rxd`  input  1  serial receive line, asynchronous, idle high
- `txd`  output  1  serial transmit line, idle high

## Operation
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
- `rxd` passes through a 2-flop synchronizer; all RX logic uses the synchronized value.
- RX states: IDLE, START, DATA, STOP.
  - IDLE: falling edge (previous synchronized 1, current 0) -> START, bit counter cleared.
  - START: after HALF cycles sample; 0 -> DATA; 1 -> IDLE (glitch rejected, no byte).
  - DATA: sample every DIV cycles, shift in LSB first; after 8th bit -> STOP.
  - STOP: sample after DIV cycles; 1 -> byte written to buffer, IDLE; 0 -> framing error, byte discarded, IDLE.
- TX states: IDLE, START, DATA, STOP.
  - IDLE: buffer non-empty -> pop byte, START; `txd`=1 while idle.
  - START: `txd`=0 for DIV cycles; DATA: each bit for DIV cycles LSB first; STOP: `txd`=1 for DIV cycles, then IDLE.
  - Back-to-back: if buffer non-empty at end of STOP, next START begins the following cycle.
- `txd` is registered (no combinational path from `rxd`).
- Buffer overflow: a completed byte arriving when the buffer is full is dropped; stored bytes are unaffected.

## Timing
- Reset: `txd`=1, both FSMs IDLE, counters 0, buffer empty, synchronizer flops 1; takes effect on the first rising edge with `rst_n`=1.
- Reset mid-frame: RX and TX abort; `txd`=1 on the cycle after the reset edge; partial bytes discarded.
- RX start detection latency: 2 cycles (synchronizer) + 1 edge-detect cycle after `rxd` falls.
- Sample points: start at detection+HALF, data bit n at detection+HALF+(n+1)·DIV, stop at detection+HALF+9·DIV.
- Echo latency: `txd` falls (start bit) within 3 cycles of the stop-bit sample when TX is idle and buffer was empty.
- Each TX bit lasts exactly DIV cycles; a full frame is exactly 10·DIV cycles.
- Simultaneous buffer write and read in one cycle: both take effect; occupancy unchanged.

## Configuration
- `UART_LOOPBACK_FIFO_EN` defined: buffer is a 16-entry FIFO (4-bit pointers with wrap, separate full/empty flags); overflow rule applies at 16 entries.
- Not defined: buffer is a single-byte holding register with valid flag; a byte completed while the register is valid (TX has not yet popped it) is dropped.

## Test plan
- Reset: hold `rst_n`=1 for 5 cycles, `rxd`=1 -> `txd`=1 throughout and for 20·DIV cycles after; no frame emitted.
- Single byte: send 0x55 at DIV=434 -> `txd` emits frame 0,1,0,1,0,1,0,1,0,1 with each bit 434 cycles, start within 3 cycles of the RX stop sample.
- Framing error: send 0xA3 with stop bit 0 -> `txd` stays 1 for 20·DIV cycles.
- Glitch: drive `rxd` low for 50 cycles then high -> no frame on `txd`.
- Back-to-back: send 0x00 then 0xFF with no idle gap -> `txd` emits 0x00 then 0xFF contiguous, 20·DIV cycles total (FIFO build: also 3 consecutive bytes 0x12,0x34,0x56 echoed in order).
- Reset mid-TX: assert `rst_n` during TX bit 4 of 0x0F -> `txd`=1 next cycle, no further bits of that frame.
